// File: rtl/rocc_pkg.sv
// Shared types for the RoCC dispatch path: channel FSM states, channel-select
// field location and the default queued-command record.
package rocc_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} ch_state_e;

    localparam int ROCC_CH_LSB = 12;
    localparam int ROCC_CH_W   = 3;
    localparam int ROCC_XLEN   = 32;

    typedef struct packed {
        logic [ROCC_XLEN-1:0] instr;
        logic [ROCC_XLEN-1:0] rs1;
        logic [ROCC_XLEN-1:0] rs2;
        logic [ROCC_CH_W-1:0] ch;
    } rocc_cmd_t;

endpackage

// File: rtl/rocc_cmd_fifo.sv
// In-order command queue with a combinational head. Pointers wrap naturally
// because DEPTH is a power of two.
module rocc_cmd_fifo
    import rocc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = rocc_cmd_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  T                           wr_data,
    input  logic                       rd_en,
    output T                           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           we, re;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign we      = wr_en & ~full;
    assign re      = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (we) wr_ptr <= wr_ptr + AW'(1);
            if (re) rd_ptr <= rd_ptr + AW'(1);
            case ({we, re})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no clear; only pointers define validity.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rocc_dispatch_unit.sv
// Queues custom instructions and issues them in order to NUM_ACC accelerator
// channels, each tracked by an IDLE -> ISSUE -> BUSY -> IDLE handshake FSM.
module rocc_dispatch_unit
    import rocc_pkg::*;
#(
    parameter int NUM_ACC = 2,
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 is_rocc,
    input  logic                                 is_fence,
    input  logic [XLEN-1:0]                      rocc_instr,
    input  logic [XLEN-1:0]                      rocc_rs1,
    input  logic [XLEN-1:0]                      rocc_rs2,
    output logic                                 stall,
    output logic [NUM_ACC-1:0]                   acc_valid,
    input  logic [NUM_ACC-1:0]                   acc_ready,
    output logic [NUM_ACC*XLEN-1:0]              acc_instr,
    output logic [NUM_ACC*XLEN-1:0]              acc_rs1,
    output logic [NUM_ACC*XLEN-1:0]              acc_rs2,
    input  logic [NUM_ACC-1:0]                   acc_done,
    output logic                                 busy,
    output logic [$clog2(DEPTH+NUM_ACC+1)-1:0]   inflight,
    output logic                                 err_bad_ch
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH+NUM_ACC+1);

    typedef struct packed {
        logic [XLEN-1:0]      instr;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [ROCC_CH_W-1:0] ch;
    } cmd_t;

    cmd_t                 wr_cmd, head;
    logic [CW-1:0]        count;
    logic                 full, empty, push, pop, ch_ok;
    logic [ROCC_CH_W-1:0] ch;
    logic [NUM_ACC-1:0]   dispatch, chan_active;

    assign ch     = rocc_instr[ROCC_CH_LSB +: ROCC_CH_W];
    assign ch_ok  = int'(ch) < NUM_ACC;
    assign busy   = ~empty | (|chan_active);
    // Uses registered full/busy only, so ready/done never reach stall combinationally.
    assign stall  = (is_rocc & full) | (is_fence & busy);
    assign push   = is_rocc & ~stall & ch_ok;
    assign pop    = |dispatch;
    assign wr_cmd = '{instr: rocc_instr, rs1: rocc_rs1, rs2: rocc_rs2, ch: ch};

    rocc_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (push),
        .wr_data (wr_cmd),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_bad_ch <= 1'b0;
        else      err_bad_ch <= is_rocc & ~stall & ~ch_ok;
    end

    always_comb begin
        inflight = IW'(count);
        for (int i = 0; i < NUM_ACC; i++) inflight = inflight + IW'(chan_active[i]);
    end

    for (genvar i = 0; i < NUM_ACC; i++) begin : g_ch
        ch_state_e       state, state_nxt;
        logic            valid_o, active_o;
        logic [XLEN-1:0] p_instr, p_rs1, p_rs2;

        // Only the head may dispatch, so a blocked head stalls every later entry.
        assign dispatch[i] = ~empty & (head.ch == ROCC_CH_W'(i)) & (state == IDLE);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) state <= IDLE;
            else      state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (dispatch[i])  state_nxt = ISSUE;
                ISSUE:   if (acc_ready[i]) state_nxt = BUSY;
                BUSY:    if (acc_done[i])  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        always_comb begin
            valid_o  = (state == ISSUE);
            active_o = (state != IDLE);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                p_instr <= '0;
                p_rs1   <= '0;
                p_rs2   <= '0;
            end else if (dispatch[i]) begin
                p_instr <= head.instr;
                p_rs1   <= head.rs1;
                p_rs2   <= head.rs2;
            end
        end

        assign acc_valid[i]                 = valid_o;
        assign chan_active[i]               = active_o;
        assign acc_instr[i*XLEN +: XLEN]    = p_instr;
        assign acc_rs1[i*XLEN +: XLEN]      = p_rs1;
        assign acc_rs2[i*XLEN +: XLEN]      = p_rs2;
    end

endmodule
